pdm_modulator: RTL and testbench

//  Second-order delta-sigma modulator: turns signed PCM samples into a 1-bit
//  PDM stream at OSR bits per sample. Transmit-side counterpart of the cic

---
 rtl/pdm_modulator.sv | 131 +++++++++++++
 tb/tb_pdm_modulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_modulator
//  Purpose  : Second-order delta-sigma modulator, signed PCM in, 1-bit PDM
//             out at OSR bits per sample, with a one-deep input holding reg.
//  Revision : 1.0  initial release
// ============================================================================
module pdm_modulator #(
    parameter int IN_W = 24,
    parameter int OSR  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [IN_W-1:0] pcm_in,
    input  logic                   pcm_valid,
    output logic                   pcm_ready,
    output logic                   frame,
    output logic                   underrun,
    output logic                   dout
);

    localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int I1_W = IN_W + 2;
    localparam int I2_W = IN_W + 4;

    localparam logic signed [IN_W-1:0] c_CLAMP_POS = {3'b011, {(IN_W-3){1'b0}}};
    localparam logic signed [IN_W-1:0] c_CLAMP_NEG = {3'b101, {(IN_W-3){1'b0}}};
    localparam logic [I1_W-1:0]        c_FB_POS    = {3'b001, {(IN_W-1){1'b0}}};
    localparam logic [I1_W-1:0]        c_FB_NEG    = {3'b111, {(IN_W-1){1'b0}}};
    localparam logic [I1_W-1:0]        c_I1_MAX    = {1'b0, {(I1_W-1){1'b1}}};
    localparam logic [I1_W-1:0]        c_I1_MIN    = {1'b1, {(I1_W-1){1'b0}}};
    localparam logic [I2_W-1:0]        c_I2_MAX    = {1'b0, {(I2_W-1){1'b1}}};
    localparam logic [I2_W-1:0]        c_I2_MIN    = {1'b1, {(I2_W-1){1'b0}}};

    logic [PH_W-1:0] r_phase;
    logic [IN_W-1:0] r_hold;
    logic            r_hold_full;
    logic [IN_W-1:0] r_x;
    logic [I1_W-1:0] r_i1;
    logic [I2_W-1:0] r_i2;
    logic            r_dout;
    logic            r_frame;
    logic            r_underrun;

    logic            w_accept;
    logic            w_bnd;
    logic [IN_W-1:0] w_clamped;
    logic [I1_W-1:0] w_fb;
    logic [I1_W:0]   w_s1;
    logic [I1_W-1:0] w_i1n;
    logic [I2_W:0]   w_s2;
    logic [I2_W-1:0] w_i2n;

    assign pcm_ready = reset && !r_hold_full;
    assign w_accept  = pcm_valid && pcm_ready;
    assign w_bnd     = (r_phase == PH_W'(OSR - 1));

    always_comb begin
        w_clamped = pcm_in;
        if (pcm_in > c_CLAMP_POS) begin
            w_clamped = c_CLAMP_POS;
        end else if (pcm_in < c_CLAMP_NEG) begin
            w_clamped = c_CLAMP_NEG;
        end
    end

    // One guard bit on each sum; differing top bits flag overflow for clamping.
    assign w_fb = r_dout ? c_FB_POS : c_FB_NEG;
    assign w_s1 = {r_i1[I1_W-1], r_i1} + {{3{r_x[IN_W-1]}}, r_x} - {w_fb[I1_W-1], w_fb};
    assign w_s2 = {r_i2[I2_W-1], r_i2} + {{3{w_i1n[I1_W-1]}}, w_i1n}
                - {{3{w_fb[I1_W-1]}}, w_fb};

    always_comb begin
        w_i1n = w_s1[I1_W-1:0];
        if (w_s1[I1_W] != w_s1[I1_W-1]) begin
            w_i1n = w_s1[I1_W] ? c_I1_MIN : c_I1_MAX;
        end
    end

    always_comb begin
        w_i2n = w_s2[I2_W-1:0];
        if (w_s2[I2_W] != w_s2[I2_W-1]) begin
            w_i2n = w_s2[I2_W] ? c_I2_MIN : c_I2_MAX;
        end
    end

    // Accept and frame load are mutually exclusive: one needs hold empty, the other full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_x         <= '0;
            r_frame     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_phase <= r_phase + PH_W'(1);
            r_frame <= w_bnd;
            if (w_bnd) begin
                if (r_hold_full) begin
                    r_x         <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_underrun  <= 1'b1;
                end
            end
            if (w_accept) begin
                r_hold      <= w_clamped;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i1   <= '0;
            r_i2   <= '0;
            r_dout <= 1'b0;
        end else begin
            r_i1   <= w_i1n;
            r_i2   <= w_i2n;
            r_dout <= !w_i2n[I2_W-1];
        end
    end

    assign frame    = r_frame;
    assign underrun = r_underrun;
    assign dout     = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_pdm_modulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pdm_modulator
//  Purpose  : Self-checking bench: sample-queue scoreboard driving a cycle
//             model, DC-level vector table and handshake/underrun/reset cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pdm_modulator;

    localparam int     IN_W = 24;
    localparam int     OSR  = 64;
    localparam longint FS   = longint'(1) <<< (IN_W - 1);

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic signed [IN_W-1:0] pcm_in = '0;
    logic                   pcm_valid = 1'b0;
    logic                   pcm_ready;
    logic                   frame;
    logic                   underrun;
    logic                   dout;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pdm_modulator #(.IN_W(IN_W), .OSR(OSR)) dut (
        .clk       (clk),
        .reset     (reset),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .frame     (frame),
        .underrun  (underrun),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d..%0d", nm, $time, got, lo, hi);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -(longint'(1) <<< (w - 1));
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    function automatic longint clampf(input longint v);
        longint lim = 3 * FS / 4;
        return (v > lim) ? lim : ((v < -lim) ? -lim : v);
    endfunction

    // Scoreboard: accepted samples queue until a frame boundary pulls them into the model.
    longint q[$];
    longint m_i1 = 0, m_i2 = 0, m_x = 0;
    bit     m_dout = 1'b0, m_frame = 1'b0, m_underrun = 1'b0;
    int     m_phase = 0;

    always @(posedge clk or negedge reset) begin
        longint fb, i1n, i2n;
        bit     acc;
        if (!reset) begin
            m_i1 = 0; m_i2 = 0; m_x = 0; m_phase = 0;
            m_dout = 1'b0; m_frame = 1'b0; m_underrun = 1'b0;
            q.delete();
        end else begin
            fb  = m_dout ? FS : -FS;
            i1n = sat(m_i1 + m_x - fb, IN_W + 2);
            i2n = sat(m_i2 + i1n - fb, IN_W + 4);
            acc = pcm_valid && (q.size() == 0);
            m_frame = (m_phase == OSR - 1);
            if (m_frame) begin
                if (q.size() > 0) m_x = q.pop_front();
                else              m_underrun = 1'b1;
            end
            if (acc) q.push_back(clampf(longint'(pcm_in)));
            m_i1 = i1n; m_i2 = i2n; m_dout = (i2n >= 0);
            m_phase = (m_phase + 1) % OSR;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout",      longint'(dout),      longint'(m_dout));
            chk("frame",     longint'(frame),     longint'(m_frame));
            chk("underrun",  longint'(underrun),  longint'(m_underrun));
            chk("pcm_ready", longint'(pcm_ready), longint'(reset && q.size() == 0));
        end
    end

    typedef struct {
        logic signed [IN_W-1:0] s;
        int                     lo;
        int                     hi;
        string                  name;
    } vec_t;

    vec_t vt[6];

    task automatic count_ones(output int n);
        n = 0;
        repeat (OSR) begin
            @(negedge clk);
            n += int'(dout);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        bit got;
        logic signed [IN_W-1:0] seqv[6];

        vt[0] = '{24'sh000000, 31, 33, "zero"};
        vt[1] = '{24'sh400000, 46, 50, "half_pos"};
        vt[2] = '{24'sh200000, 38, 42, "quarter_pos"};
        vt[3] = '{24'sh7FFFFF, 54, 58, "max_clamped"};
        vt[4] = '{24'shC00000, 14, 18, "half_neg"};
        vt[5] = '{24'sh800000,  6, 10, "min_clamped"};
        seqv[0] = 24'sh100000; seqv[1] = 24'shF00000; seqv[2] = 24'sh300000;
        seqv[3] = 24'shD00000; seqv[4] = 24'sh050000; seqv[5] = 24'shFB0000;

        // reset state
        #3;
        chk("rst_dout", longint'(dout), 0);
        chk("rst_frame", longint'(frame), 0);
        chk("rst_underrun", longint'(underrun), 0);
        chk("rst_ready", longint'(pcm_ready), 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        pcm_in = vt[0].s;
        pcm_valid = 1'b1;
        chk_en = 1'b1;

        // DC levels: settle several frames, then count ones over one frame
        for (int i = 0; i < 6; i++) begin
            pcm_in = vt[i].s;
            repeat (8 * OSR) @(negedge clk);
            count_ones(n);
            chk_rng(vt[i].name, n, vt[i].lo, vt[i].hi);
        end

        // back-to-back distinct samples: one transfer per frame, ready low while full
        for (int k = 0; k < 6; k++) begin
            pcm_in = seqv[k];
            got = 1'b0;
            for (int c = 0; c < 3 * OSR; c++) begin
                @(negedge clk);
                if (pcm_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("hs_ready_seen", longint'(got), 1);
            @(negedge clk);
            chk("hs_ready_low_full", longint'(pcm_ready), 0);
        end

        // starve one frame: sticky underrun
        chk("underrun_before_gap", longint'(underrun), 0);
        pcm_valid = 1'b0;
        repeat (3 * OSR) @(negedge clk);
        chk("underrun_after_gap", longint'(underrun), 1);
        pcm_valid = 1'b1;
        pcm_in = 24'sh100000;
        repeat (2 * OSR) @(negedge clk);
        chk("underrun_sticky", longint'(underrun), 1);

        // async reset at phase 30 with the hold register full
        got = 1'b0;
        for (int c = 0; c < 2 * OSR; c++) begin
            @(negedge clk);
            if (frame) begin
                got = 1'b1;
                break;
            end
        end
        chk("frame_seen", longint'(got), 1);
        repeat (30) @(posedge clk);
        #2;
        chk("pre_rst_ready_low", longint'(pcm_ready), 0);
        reset = 1'b0;
        #1;
        chk("arst_dout", longint'(dout), 0);
        chk("arst_frame", longint'(frame), 0);
        chk("arst_underrun", longint'(underrun), 0);
        chk("arst_ready", longint'(pcm_ready), 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 3 * OSR; c++) begin
            @(posedge clk);
            n++;
            #1;
            if (frame) break;
        end
        chk("first_frame_after_rst", longint'(n), OSR);
        repeat (4 * OSR) @(negedge clk);
        chk("no_underrun_after_rst", longint'(underrun), 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
